beat_editor: RTL
================

Name: beat_editor

Overview:
- Sits directly downstream of button_matrix_controller and upstream of model.
- Consumes the raw scanned button_index and button_pressed signals and debounces each press.
- On every accepted press, advances the 3-bit sound value of the pressed step: 16 steps, one per button.
- Emits a single-cycle write command {step[3:0], value[2:0]} that drives model's 7-bit data_in, and keeps a shadow copy of all 16 step values.

Parameters:
- DEBOUNCE_CYCLES, 120000, consecutive stable cycles needed to accept a press or a release (10 ms at 12 MHz); legal range 2 to 2^20-1.
- NUM_VALUES, 8, number of sound values per step; a value cycles 0..NUM_VALUES-1 and then wraps to 0; legal range 2 to 8.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- button_index  input  4  scanned button index, from button_matrix_controller
- button_pressed  input  1  high while any button is detected, from button_matrix_controller
- data_out  output  7  write command {step[3:0], value[2:0]}, to model data_in
- data_valid  output  1  one-cycle strobe qualifying data_out
- step_values  output  48  shadow copy of step values; step n occupies bits [3n+2:3n]
- busy  output  1  high in every state except IDLE

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values:
  - data_out = 0, data_valid = 0, step_values = 0, busy = 0.
  - State = IDLE, debounce counter = 0, input sample registers = 0.
  - Reset asserted mid-operation aborts any debounce or hold; no strobe is emitted in the reset cycle.
- Input stage: button_index and button_pressed are registered once (s_idx, s_prs). All decisions use the registered copies.
- States: IDLE, DEB_PRESS, EMIT, HELD, DEB_RELEASE.
- IDLE:
  - If s_prs=1: latch lat_idx=s_idx, set cnt=1, go to DEB_PRESS.
  - Otherwise stay in IDLE.
- DEB_PRESS:
  - If s_prs=1 and s_idx==lat_idx: cnt++.
  - When cnt reaches DEBOUNCE_CYCLES, go to EMIT.
  - If s_prs=0 or s_idx!=lat_idx: go to IDLE with cnt=0. No command is emitted.
- EMIT (exactly one cycle):
  - nv = (step_values[lat_idx]==NUM_VALUES-1) ? 0 : step_values[lat_idx]+1.
  - Write nv into step_values[lat_idx].
  - Register data_out={lat_idx,nv} and data_valid=1; both become visible the cycle after EMIT.
  - Go to HELD.
- HELD:
  - Ignore s_idx, so a second simultaneous button is never accepted.
  - If s_prs=0: set cnt=1, go to DEB_RELEASE.
- DEB_RELEASE:
  - If s_prs=0: cnt++; when cnt reaches DEBOUNCE_CYCLES, go to IDLE.
  - If s_prs=1: go back to HELD. The press is still the same one and is not re-emitted.
- Latency: input sampled high at edge E0 (the first edge at which s_prs=1) → data_valid high at edge E0+DEBOUNCE_CYCLES+2, for exactly one cycle.
- data_valid rules:
  - Never high on two consecutive cycles.
  - At most one strobe per physical press.
- data_out holds its last command between strobes. Consumers must qualify it with data_valid.
- Value arithmetic:
  - 3-bit unsigned.
  - With NUM_VALUES=8 the wrap from 7 to 0 is natural overflow.
  - With NUM_VALUES<8, values at or above NUM_VALUES are unreachable.
- busy = (state != IDLE).

Test Plan:
- Bench setting: DEBOUNCE_CYCLES=4, NUM_VALUES=8 unless stated otherwise.
- Stable press: idx=5 held 10 cycles, then released ≥6 cycles → exactly one strobe with data_out=0x29 ({5,1}); step_values[17:15]=1; all other bits 0; busy returns to 0.
- Bounce rejection: idx=3 pressed for 2 cycles, released 1 cycle, repeated ×5 → no strobe; step_values stays 0. Then a stable press → one strobe with data_out=0x19 ({3,1}).
- Wrap-around: press idx=15 nine times, each with full release → values 1,2,…,7,0,1; the eighth strobe is data_out=0x78 ({15,0}). Repeat with NUM_VALUES=5 on idx=0 → sequence 1,2,3,4,0.
- Hold and release glitch: idx=7 held 20 cycles, with a 1-cycle high glitch inserted during release debounce → exactly one strobe ({7,1}). A second press then gives {7,2}.
- Index change: idx=2 for 2 cycles, then idx=9 while still pressed → DEB_PRESS restarts; strobe {9,1} only, and step 2 stays 0. In HELD, a switch to idx=4 produces no strobe.
- Reset mid-operation: rst asserted in DEB_PRESS and in HELD after the strobe → all outputs 0 the next cycle, step_values=0, state IDLE; a later press of the same idx yields value 1.

Source files
------------

// File: rtl/beat_editor.sv
// Debounces scanned button presses and steps the per-button sound value, emitting one
// write command {step, value} per accepted press and keeping a shadow copy of all steps.
module beat_editor #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned NUM_VALUES      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  button_index,
  input  logic        button_pressed,
  output logic [6:0]  data_out,
  output logic        data_valid,
  output logic [47:0] step_values,
  output logic        busy
);

  typedef enum logic [2:0] {
    StIdle,
    StDebPress,
    StEmit,
    StHeld,
    StDebRelease
  } state_e;

  localparam logic [19:0] CntMax = 20'(DEBOUNCE_CYCLES);
  localparam logic [2:0]  ValMax = 3'(NUM_VALUES - 1);

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  s_idx_q;
  logic        s_prs_q;
  logic [3:0]  lat_idx_q, lat_idx_d;
  logic [6:0]  data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic [47:0] step_values_q, step_values_d;
  logic [2:0]  cur_val, nxt_val;

  assign cur_val = step_values_q[lat_idx_q*3 +: 3];
  assign nxt_val = (cur_val == ValMax) ? 3'd0 : cur_val + 3'd1;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lat_idx_d     = lat_idx_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    step_values_d = step_values_q;
    unique case (state_q)
      StIdle: begin
        if (s_prs_q) begin
          lat_idx_d = s_idx_q;
          cnt_d     = 20'd1;
          state_d   = StDebPress;
        end
      end
      StDebPress: begin
        // A release or a different button restarts the whole debounce from idle.
        if (!s_prs_q || (s_idx_q != lat_idx_q)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          state_d = StEmit;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      StEmit: begin
        step_values_d[lat_idx_q*3 +: 3] = nxt_val;
        data_out_d                      = {lat_idx_q, nxt_val};
        data_valid_d                    = 1'b1;
        state_d                         = StHeld;
      end
      StHeld: begin
        if (!s_prs_q) begin
          cnt_d   = 20'd1;
          state_d = StDebRelease;
        end
      end
      StDebRelease: begin
        if (s_prs_q) begin
          state_d = StHeld;
        end else if (cnt_q == CntMax) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      s_idx_q       <= '0;
      s_prs_q       <= 1'b0;
      lat_idx_q     <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      step_values_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      s_idx_q       <= button_index;
      s_prs_q       <= button_pressed;
      lat_idx_q     <= lat_idx_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      step_values_q <= step_values_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign step_values = step_values_q;
  assign busy        = (state_q != StIdle);

endmodule
